// File: rtl/alu_mc.sv
// Handshaked ALU: single-cycle logic/arith ops plus iterative shift-add MUL and
// restoring DIVU, one bit per cycle. Results are registered and held until taken.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       ALU_Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             Zero,
    output logic             ALUcomplete,
    output logic             busy
);

    localparam int SH_W = $clog2(WIDTH);
    localparam logic [SH_W-1:0] LAST = SH_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, out_q, out_d;
    logic             zero_q, zero_d, cplt_q, cplt_d;
    logic [SH_W-1:0]  cnt_q, cnt_d;

    logic             accept;
    logic [SH_W-1:0]  sh;
    logic [SH_W:0]    sh_inv;
    logic [WIDTH-1:0] sc_res;
    logic             sc_legal;
    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH:0]   rem_sh, diff;
    logic             q_bit;
    logic [WIDTH-1:0] quo_next;

    assign in_ready    = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
    assign accept      = in_valid && in_ready;
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q == S_MUL) || (state_q == S_DIV);
    assign ALU_Out     = out_q;
    assign Zero        = zero_q;
    assign ALUcomplete = cplt_q;

    // Rotates use the complementary shift; sh_inv == WIDTH when sh == 0 yields zero.
    assign sh     = B[SH_W-1:0];
    assign sh_inv = (SH_W+1)'(WIDTH) - {1'b0, sh};

    always_comb begin
        sc_res   = '0;
        sc_legal = 1'b1;
        case (ALU_Sel)
            5'h00: sc_res = A + B;
            5'h01: sc_res = A - B;
            5'h04: sc_res = A << sh;
            5'h05: sc_res = A >> sh;
            5'h06: sc_res = (A << sh) | (A >> sh_inv);
            5'h07: sc_res = (A >> sh) | (A << sh_inv);
            5'h08: sc_res = A & B;
            5'h09: sc_res = A | B;
            5'h0A: sc_res = A ^ B;
            5'h0B: sc_res = ~(A | B);
            5'h0C: sc_res = ~(A & B);
            5'h0D: sc_res = WIDTH'(A < B);
            5'h0E: sc_res = WIDTH'($signed(A) < $signed(B));
            5'h0F: sc_res = $unsigned($signed(A) >>> sh);
            5'h10: sc_res = WIDTH'($signed(A[7:0]));
            5'h11: sc_res = WIDTH'($signed(A[15:0]));
            5'h12: sc_res = WIDTH'(A[7:0]);
            5'h13: sc_res = WIDTH'(A[15:0]);
            5'h02, 5'h03: sc_res = '0;
            default: sc_legal = 1'b0;
        endcase
    end

    // MUL: a_q is the left-shifting multiplicand, b_q the right-shifting multiplier.
    // DIV: a_q shifts dividend out / quotient in, acc_q is the partial remainder.
    assign mul_sum  = acc_q + (b_q[0] ? a_q : '0);
    assign rem_sh   = {acc_q, a_q[WIDTH-1]};
    assign diff     = rem_sh - {1'b0, b_q};
    assign q_bit    = ~diff[WIDTH];
    assign quo_next = {a_q[WIDTH-2:0], q_bit};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        zero_d  = zero_q;
        cplt_d  = cplt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE && out_ready)
                    state_d = S_IDLE;
                if (accept) begin
                    a_d   = A;
                    b_d   = B;
                    acc_d = '0;
                    cnt_d = '0;
                    case (ALU_Sel)
                        5'h02: state_d = S_MUL;
                        5'h03: state_d = S_DIV;
                        default: begin
                            state_d = S_DONE;
                            out_d   = sc_res;
                            zero_d  = (sc_res == '0);
                            cplt_d  = sc_legal;
                        end
                    endcase
                end
            end
            S_MUL: begin
                acc_d = mul_sum;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    out_d   = mul_sum;
                    zero_d  = (mul_sum == '0);
                    cplt_d  = 1'b1;
                end
            end
            S_DIV: begin
                acc_d = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                a_d   = quo_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    out_d   = quo_next;
                    zero_d  = (quo_next == '0);
                    cplt_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            cplt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            cplt_q  <= cplt_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a 32-bit and a 16-bit instance share stimulus buses.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  sel = '0;
    logic [31:0] a = '0, b = '0;
    logic        out_ready = 1'b1;
    logic        iv32 = 1'b0, iv16 = 1'b0;

    logic        ir32, ov32, z32, c32, bz32;
    logic [31:0] r32;
    logic        ir16, ov16, z16, c16, bz16;
    logic [15:0] r16;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
        .A(a), .B(b), .ALU_Sel(sel), .out_valid(ov32), .out_ready(out_ready),
        .ALU_Out(r32), .Zero(z32), .ALUcomplete(c32), .busy(bz32)
    );

    alu_mc #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .A(a[15:0]), .B(b[15:0]), .ALU_Sel(sel), .out_valid(ov16), .out_ready(out_ready),
        .ALU_Out(r16), .Zero(z16), .ALUcomplete(c16), .busy(bz16)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic obs(input bit w16, output logic ov, output logic ir, output logic bz,
                       output logic z, output logic c, output logic [31:0] r);
        if (w16) begin
            ov = ov16; ir = ir16; bz = bz16; z = z16; c = c16; r = {16'h0, r16};
        end else begin
            ov = ov32; ir = ir32; bz = bz32; z = z32; c = c32; r = r32;
        end
    endtask

    // Issue one op with out_ready high, wait for the result and check it.
    task automatic run(input string tag, input bit w16, input logic [4:0] op,
                       input logic [31:0] av, input logic [31:0] bv, input logic [31:0] exp,
                       input int lat_exp, input logic zexp, input logic cexp);
        logic ov, ir, bz, z, c;
        logic [31:0] r;
        int lat, bcnt;
        obs(w16, ov, ir, bz, z, c, r);
        chk({tag, ":in_ready"}, ir, 1);
        sel = op; a = av; b = bv;
        if (w16) iv16 = 1'b1; else iv32 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0; iv32 = 1'b0;
        lat = 1;
        obs(w16, ov, ir, bz, z, c, r);
        bcnt = int'(bz);
        while (!ov && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            obs(w16, ov, ir, bz, z, c, r);
            bcnt += int'(bz);
        end
        chk({tag, ":latency"}, lat, lat_exp);
        chk({tag, ":busy_cycles"}, bcnt, lat_exp - 1);
        chk({tag, ":out"}, r, exp);
        chk({tag, ":zero"}, z, zexp);
        chk({tag, ":complete"}, c, cexp);
    endtask

    logic [31:0] tp_exp [4] = '{32'd10, 32'd11, 32'd12, 32'd13};

    initial begin
        int lat, nov;
        repeat (3) @(posedge clk);
        #1;
        chk("reset:out_valid", ov32, 0);
        chk("reset:ALU_Out", r32, 0);
        chk("reset:Zero", z32, 0);
        chk("reset:ALUcomplete", c32, 0);
        chk("reset:busy", bz32, 0);
        chk("reset:in_ready", ir32, 1);
        rst = 1'b0;

        run("add", 0, 5'h00, 32'd5, 32'd3, 32'd8, 1, 0, 1);
        run("divu", 0, 5'h03, 32'd6, 32'd2, 32'd3, 33, 0, 1);
        run("divu0", 0, 5'h03, 32'd6, 32'd0, 32'hFFFFFFFF, 33, 0, 1);
        run("slt", 0, 5'h0E, 32'hFFFFFFFB, 32'hFFFFFFF6, 32'd0, 1, 1, 1);
        run("sltu", 0, 5'h0D, 32'd5, 32'd10, 32'd1, 1, 0, 1);
        run("illegal", 0, 5'h1F, 32'hBF3DD6B5, 32'd0, 32'd0, 1, 1, 0);
        run("sext8", 0, 5'h10, 32'hBF3DD6B5, 32'd0, 32'hFFFFFFB5, 1, 0, 1);
        run("sub_wrap", 0, 5'h01, 32'd0, 32'd1, 32'hFFFFFFFF, 1, 0, 1);
        run("add_wrap", 0, 5'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 1, 1);
        run("sll_hiB", 0, 5'h04, 32'd1, 32'h21, 32'd2, 1, 0, 1);
        run("srl", 0, 5'h05, 32'h80000000, 32'd31, 32'd1, 1, 0, 1);
        run("rol", 0, 5'h06, 32'h80000001, 32'd4, 32'h18, 1, 0, 1);
        run("ror", 0, 5'h07, 32'd1, 32'd1, 32'h80000000, 1, 0, 1);
        run("rol0", 0, 5'h06, 32'h12345678, 32'h40, 32'h12345678, 1, 0, 1);
        run("sra", 0, 5'h0F, 32'h80000000, 32'd4, 32'hF8000000, 1, 0, 1);
        run("and", 0, 5'h08, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1, 0, 1);
        run("or", 0, 5'h09, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1, 0, 1);
        run("xor", 0, 5'h0A, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1, 0, 1);
        run("nor", 0, 5'h0B, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1, 0, 1);
        run("nand", 0, 5'h0C, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 1, 0, 1);
        run("sext16", 0, 5'h11, 32'h00008001, 32'd0, 32'hFFFF8001, 1, 0, 1);
        run("zext8", 0, 5'h12, 32'hFFFFFF80, 32'd0, 32'h00000080, 1, 0, 1);
        run("zext16", 0, 5'h13, 32'h12345678, 32'd0, 32'h00005678, 1, 0, 1);
        run("mul_ff", 0, 5'h02, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 33, 0, 1);
        run("divu_big", 0, 5'h03, 32'hFFFFFFFF, 32'd10, 32'h19999999, 33, 0, 1);
        @(posedge clk); #1;

        // Backpressure on a MUL result, then release with a same-cycle new accept.
        out_ready = 1'b0;
        sel = 5'h02; a = 32'd2; b = 32'd3; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        lat = 1;
        while (!ov32 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp:latency", lat, 33);
        chk("bp:out", r32, 6);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp:hold_valid", ov32, 1);
            chk("bp:hold_out", r32, 6);
            chk("bp:hold_in_ready", ir32, 0);
        end
        sel = 5'h00; a = 32'd1; b = 32'd1; iv32 = 1'b1; out_ready = 1'b1;
        #1;
        chk("bp:release_in_ready", ir32, 1);
        @(posedge clk); #1;
        iv32 = 1'b0;
        chk("bp:next_valid", ov32, 1);
        chk("bp:next_out", r32, 2);
        @(posedge clk); #1;
        chk("bp:drained", ov32, 0);

        // Back-to-back single-cycle ops, one result per cycle.
        iv32 = 1'b1; sel = 5'h00; b = 32'd10;
        for (int i = 0; i < 4; i++) begin
            a = i;
            @(posedge clk); #1;
            chk("tput:valid", ov32, 1);
            chk("tput:out", r32, tp_exp[i]);
        end
        iv32 = 1'b0;
        @(posedge clk); #1;
        chk("tput:drained", ov32, 0);

        // Reset in the middle of a DIV.
        sel = 5'h03; a = 32'd100; b = 32'd7; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("rst_div:busy_before", bz32, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_div:out_valid", ov32, 0);
        chk("rst_div:in_ready", ir32, 1);
        chk("rst_div:busy", bz32, 0);
        chk("rst_div:ALU_Out", r32, 0);
        nov = 0;
        repeat (40) begin
            @(posedge clk); #1;
            nov += int'(ov32);
        end
        chk("rst_div:no_stale", nov, 0);

        // Narrow instance.
        run("w16:add", 1, 5'h00, 32'd5, 32'd3, 32'd8, 1, 0, 1);
        run("w16:divu", 1, 5'h03, 32'd6, 32'd2, 32'd3, 17, 0, 1);
        run("w16:divu0", 1, 5'h03, 32'd6, 32'd0, 32'hFFFF, 17, 0, 1);
        run("w16:slt", 1, 5'h0E, 32'hFFFB, 32'hFFF6, 32'd0, 1, 1, 1);
        run("w16:sltu", 1, 5'h0D, 32'd5, 32'd10, 32'd1, 1, 0, 1);
        run("w16:mul", 1, 5'h02, 32'd300, 32'd7, 32'd2100, 17, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
